// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage of the MIPS pipeline.
// Decodes the opcode and R-type function code into a 4-bit ALU operation and
// two datapath flags. It then evaluates the 32-bit ALU operation and registers
// the result, the zero flag and the controls on the clock edge.
// Ports:
//   i_clock, i_reset     rising-edge clock, synchronous active-high reset
//   i_enable             1 = capture new outputs this edge, 0 = hold
//   i_funct_code         R-type function field
//   i_ALU_op             instruction opcode
//   i_A, i_B             operands (rs, rt or extended immediate)
//   i_shamt              instruction shamt field
//   o_result, o_zero     registered ALU result and result==0 flag
//   o_ALU_ctrl           registered ALU operation code
//   o_shamt_ctrl         registered, 1 for SLL/SRL/SRA (shift by shamt field)
//   o_last_register_ctrl registered, 1 for JAL (link to r31)
module alu_exec_unit #(
    parameter int unsigned NB_REG      = 32,
    parameter int unsigned NB_FCODE    = 6,
    parameter int unsigned NB_OPCODE   = 6,
    parameter int unsigned NB_ALU_CTRL = 4,
    parameter int unsigned NB_SHAMT    = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [NB_FCODE-1:0]    i_funct_code,
    input  logic [NB_OPCODE-1:0]   i_ALU_op,
    input  logic [NB_REG-1:0]      i_A,
    input  logic [NB_REG-1:0]      i_B,
    input  logic [NB_SHAMT-1:0]    i_shamt,
    output logic [NB_REG-1:0]      o_result,
    output logic                   o_zero,
    output logic [NB_ALU_CTRL-1:0] o_ALU_ctrl,
    output logic                   o_shamt_ctrl,
    output logic                   o_last_register_ctrl
);

    localparam int unsigned NB_HALF = NB_REG / 2;

    // ALU operation codes
    localparam logic [NB_ALU_CTRL-1:0] ALU_SLL = NB_ALU_CTRL'(0);
    localparam logic [NB_ALU_CTRL-1:0] ALU_SRL = NB_ALU_CTRL'(1);
    localparam logic [NB_ALU_CTRL-1:0] ALU_SRA = NB_ALU_CTRL'(2);
    localparam logic [NB_ALU_CTRL-1:0] ALU_ADD = NB_ALU_CTRL'(3);
    localparam logic [NB_ALU_CTRL-1:0] ALU_SUB = NB_ALU_CTRL'(4);
    localparam logic [NB_ALU_CTRL-1:0] ALU_AND = NB_ALU_CTRL'(5);
    localparam logic [NB_ALU_CTRL-1:0] ALU_OR  = NB_ALU_CTRL'(6);
    localparam logic [NB_ALU_CTRL-1:0] ALU_XOR = NB_ALU_CTRL'(7);
    localparam logic [NB_ALU_CTRL-1:0] ALU_NOR = NB_ALU_CTRL'(8);
    localparam logic [NB_ALU_CTRL-1:0] ALU_SLT = NB_ALU_CTRL'(9);
    localparam logic [NB_ALU_CTRL-1:0] ALU_LUI = NB_ALU_CTRL'(10);

    // Opcodes
    localparam logic [NB_OPCODE-1:0] OP_RTYPE = NB_OPCODE'('h00);
    localparam logic [NB_OPCODE-1:0] OP_J     = NB_OPCODE'('h02);
    localparam logic [NB_OPCODE-1:0] OP_JAL   = NB_OPCODE'('h03);
    localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'('h04);
    localparam logic [NB_OPCODE-1:0] OP_BNE   = NB_OPCODE'('h05);
    localparam logic [NB_OPCODE-1:0] OP_ADDI  = NB_OPCODE'('h08);
    localparam logic [NB_OPCODE-1:0] OP_SLTI  = NB_OPCODE'('h0a);
    localparam logic [NB_OPCODE-1:0] OP_ANDI  = NB_OPCODE'('h0c);
    localparam logic [NB_OPCODE-1:0] OP_ORI   = NB_OPCODE'('h0d);
    localparam logic [NB_OPCODE-1:0] OP_XORI  = NB_OPCODE'('h0e);
    localparam logic [NB_OPCODE-1:0] OP_LUI   = NB_OPCODE'('h0f);
    localparam logic [NB_OPCODE-1:0] OP_LB    = NB_OPCODE'('h20);
    localparam logic [NB_OPCODE-1:0] OP_LH    = NB_OPCODE'('h21);
    localparam logic [NB_OPCODE-1:0] OP_LWL   = NB_OPCODE'('h22);
    localparam logic [NB_OPCODE-1:0] OP_LW    = NB_OPCODE'('h23);
    localparam logic [NB_OPCODE-1:0] OP_LBU   = NB_OPCODE'('h24);
    localparam logic [NB_OPCODE-1:0] OP_LHU   = NB_OPCODE'('h25);
    localparam logic [NB_OPCODE-1:0] OP_SB    = NB_OPCODE'('h28);
    localparam logic [NB_OPCODE-1:0] OP_SH    = NB_OPCODE'('h29);
    localparam logic [NB_OPCODE-1:0] OP_SW    = NB_OPCODE'('h2b);

    // R-type function codes
    localparam logic [NB_FCODE-1:0] FN_SLL  = NB_FCODE'('h00);
    localparam logic [NB_FCODE-1:0] FN_SRL  = NB_FCODE'('h02);
    localparam logic [NB_FCODE-1:0] FN_SRA  = NB_FCODE'('h03);
    localparam logic [NB_FCODE-1:0] FN_SLLV = NB_FCODE'('h04);
    localparam logic [NB_FCODE-1:0] FN_SRLV = NB_FCODE'('h06);
    localparam logic [NB_FCODE-1:0] FN_SRAV = NB_FCODE'('h07);
    localparam logic [NB_FCODE-1:0] FN_JALR = NB_FCODE'('h09);
    localparam logic [NB_FCODE-1:0] FN_ADD  = NB_FCODE'('h20);
    localparam logic [NB_FCODE-1:0] FN_ADDU = NB_FCODE'('h21);
    localparam logic [NB_FCODE-1:0] FN_SUB  = NB_FCODE'('h22);
    localparam logic [NB_FCODE-1:0] FN_SUBU = NB_FCODE'('h23);
    localparam logic [NB_FCODE-1:0] FN_AND  = NB_FCODE'('h24);
    localparam logic [NB_FCODE-1:0] FN_OR   = NB_FCODE'('h25);
    localparam logic [NB_FCODE-1:0] FN_XOR  = NB_FCODE'('h26);
    localparam logic [NB_FCODE-1:0] FN_NOR  = NB_FCODE'('h27);
    localparam logic [NB_FCODE-1:0] FN_SLT  = NB_FCODE'('h2a);

    logic [NB_ALU_CTRL-1:0] alu_ctrl_c;
    logic                   shamt_ctrl_c;
    logic                   last_reg_c;
    logic [NB_SHAMT-1:0]    shift_amt_c;
    logic [NB_REG-1:0]      result_c;

    // Instruction decode; anything unrecognised falls back to ADD with both flags clear
    always_comb begin
        alu_ctrl_c   = ALU_ADD;
        shamt_ctrl_c = 1'b0;
        last_reg_c   = 1'b0;
        case (i_ALU_op)
            OP_RTYPE: begin
                case (i_funct_code)
                    FN_SLL:  begin alu_ctrl_c = ALU_SLL; shamt_ctrl_c = 1'b1; end
                    FN_SRL:  begin alu_ctrl_c = ALU_SRL; shamt_ctrl_c = 1'b1; end
                    FN_SRA:  begin alu_ctrl_c = ALU_SRA; shamt_ctrl_c = 1'b1; end
                    FN_SLLV: alu_ctrl_c = ALU_SLL;
                    FN_SRLV: alu_ctrl_c = ALU_SRL;
                    FN_SRAV: alu_ctrl_c = ALU_SRA;
                    FN_JALR, FN_ADD, FN_ADDU: alu_ctrl_c = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_ctrl_c = ALU_SUB;
                    FN_AND:  alu_ctrl_c = ALU_AND;
                    FN_OR:   alu_ctrl_c = ALU_OR;
                    FN_XOR:  alu_ctrl_c = ALU_XOR;
                    FN_NOR:  alu_ctrl_c = ALU_NOR;
                    FN_SLT:  alu_ctrl_c = ALU_SLT;
                    default: alu_ctrl_c = ALU_ADD;
                endcase
            end
            OP_JAL:  begin alu_ctrl_c = ALU_ADD; last_reg_c = 1'b1; end
            OP_BEQ, OP_BNE: alu_ctrl_c = ALU_SUB;
            OP_SLTI: alu_ctrl_c = ALU_SLT;
            OP_ANDI: alu_ctrl_c = ALU_AND;
            OP_ORI:  alu_ctrl_c = ALU_OR;
            OP_XORI: alu_ctrl_c = ALU_XOR;
            OP_LUI:  alu_ctrl_c = ALU_LUI;
            OP_J, OP_ADDI,
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: alu_ctrl_c = ALU_ADD;
            default: alu_ctrl_c = ALU_ADD;
        endcase
    end

    // Variable shifts take their amount from the low bits of A only
    assign shift_amt_c = shamt_ctrl_c ? i_shamt : i_A[NB_SHAMT-1:0];

    // ALU datapath; B is the shifted operand
    always_comb begin
        result_c = '0;
        case (alu_ctrl_c)
            ALU_SLL: result_c = i_B << shift_amt_c;
            ALU_SRL: result_c = i_B >> shift_amt_c;
            ALU_SRA: result_c = NB_REG'($signed(i_B) >>> shift_amt_c);
            ALU_ADD: result_c = i_A + i_B;
            ALU_SUB: result_c = i_A - i_B;
            ALU_AND: result_c = i_A & i_B;
            ALU_OR:  result_c = i_A | i_B;
            ALU_XOR: result_c = i_A ^ i_B;
            ALU_NOR: result_c = ~(i_A | i_B);
            ALU_SLT: result_c = NB_REG'($signed(i_A) < $signed(i_B));
            ALU_LUI: result_c = i_B << NB_HALF;
            default: result_c = '0;
        endcase
    end

    // Output register: reset wins over enable, enable low holds
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_result             <= '0;
            o_zero               <= 1'b0;
            o_ALU_ctrl           <= '0;
            o_shamt_ctrl         <= 1'b0;
            o_last_register_ctrl <= 1'b0;
        end else if (i_enable) begin
            o_result             <= result_c;
            o_zero               <= (result_c == '0);
            o_ALU_ctrl           <= alu_ctrl_c;
            o_shamt_ctrl         <= shamt_ctrl_c;
            o_last_register_ctrl <= last_reg_c;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a
// behavioural model of the instruction set semantics.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [5:0]  funct;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic [3:0]  alu_ctrl;
    logic        shamt_ctrl;
    logic        last_reg;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected registered state
    logic [31:0] exp_result = '0;
    logic        exp_zero   = 1'b0;
    logic [3:0]  exp_ctrl   = '0;
    logic        exp_sf     = 1'b0;
    logic        exp_lf     = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .i_clock              (clk),
        .i_reset              (rst),
        .i_enable             (en),
        .i_funct_code         (funct),
        .i_ALU_op             (op),
        .i_A                  (a),
        .i_B                  (b),
        .i_shamt              (shamt),
        .o_result             (result),
        .o_zero               (zero),
        .o_ALU_ctrl           (alu_ctrl),
        .o_shamt_ctrl         (shamt_ctrl),
        .o_last_register_ctrl (last_reg)
    );

    // Instruction semantics: name the operation, then evaluate it arithmetically
    task automatic model(input logic [5:0] m_op, input logic [5:0] m_fn,
                         input logic [31:0] m_a, input logic [31:0] m_b,
                         input logic [4:0] m_sh,
                         output logic [31:0] r, output logic [3:0] c,
                         output logic sf, output logic lf);
        string name;
        int    amt;
        name = "ADD";
        sf = 1'b0;
        lf = 1'b0;
        if (m_op == 6'h00) begin
            case (m_fn)
                6'h00: begin name = "SLL"; sf = 1'b1; end
                6'h02: begin name = "SRL"; sf = 1'b1; end
                6'h03: begin name = "SRA"; sf = 1'b1; end
                6'h04: name = "SLL";
                6'h06: name = "SRL";
                6'h07: name = "SRA";
                6'h22, 6'h23: name = "SUB";
                6'h24: name = "AND";
                6'h25: name = "OR";
                6'h26: name = "XOR";
                6'h27: name = "NOR";
                6'h2a: name = "SLT";
                default: name = "ADD";
            endcase
        end else begin
            case (m_op)
                6'h03: lf = 1'b1;
                6'h04, 6'h05: name = "SUB";
                6'h0a: name = "SLT";
                6'h0c: name = "AND";
                6'h0d: name = "OR";
                6'h0e: name = "XOR";
                6'h0f: name = "LUI";
                default: name = "ADD";
            endcase
        end
        amt = sf ? int'(m_sh) : int'(m_a % 32);
        case (name)
            "SLL": begin c = 4'd0; r = m_b; for (int i = 0; i < amt; i++) r = r * 2; end
            "SRL": begin c = 4'd1; r = m_b; for (int i = 0; i < amt; i++) r = r / 2; end
            "SRA": begin
                c = 4'd2; r = m_b;
                for (int i = 0; i < amt; i++) r = {m_b[31], r[31:1]};
            end
            "SUB": begin c = 4'd4; r = m_a + (~m_b + 32'd1); end
            "AND": begin c = 4'd5; r = m_a & m_b; end
            "OR":  begin c = 4'd6; r = m_a | m_b; end
            "XOR": begin c = 4'd7; r = m_a ^ m_b; end
            "NOR": begin c = 4'd8; r = ~(m_a | m_b); end
            "SLT": begin c = 4'd9; r = ($signed(m_a) < $signed(m_b)) ? 32'd1 : 32'd0; end
            "LUI": begin c = 4'd10; r = {m_b[15:0], 16'h0000}; end
            default: begin c = 4'd3; r = m_a + m_b; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare every output
    task automatic step(input string tag, input logic s_rst, input logic s_en,
                        input logic [5:0] s_op, input logic [5:0] s_fn,
                        input logic [31:0] s_a, input logic [31:0] s_b,
                        input logic [4:0] s_sh);
        logic [31:0] r;
        logic [3:0]  c;
        logic        sf, lf;
        @(negedge clk);
        rst = s_rst; en = s_en; op = s_op; funct = s_fn;
        a = s_a; b = s_b; shamt = s_sh;
        @(posedge clk);
        #1;
        if (s_rst) begin
            exp_result = '0; exp_zero = 1'b0; exp_ctrl = '0; exp_sf = 1'b0; exp_lf = 1'b0;
        end else if (s_en) begin
            model(s_op, s_fn, s_a, s_b, s_sh, r, c, sf, lf);
            exp_result = r; exp_zero = (r == 32'd0); exp_ctrl = c; exp_sf = sf; exp_lf = lf;
        end
        check({tag, ".result"},   result,            exp_result);
        check({tag, ".zero"},     32'(zero),         32'(exp_zero));
        check({tag, ".ctrl"},     32'(alu_ctrl),     32'(exp_ctrl));
        check({tag, ".shamt"},    32'(shamt_ctrl),   32'(exp_sf));
        check({tag, ".lastreg"},  32'(last_reg),     32'(exp_lf));
    endtask

    // Directed step that also checks result and flags against hand-derived constants
    task automatic dir(input string tag, input logic [5:0] d_op, input logic [5:0] d_fn,
                       input logic [31:0] d_a, input logic [31:0] d_b, input logic [4:0] d_sh,
                       input logic [31:0] want, input logic [3:0] want_ctrl,
                       input logic want_sf, input logic want_lf);
        step(tag, 1'b0, 1'b1, d_op, d_fn, d_a, d_b, d_sh);
        check({tag, ".const_result"}, result,          want);
        check({tag, ".const_zero"},   32'(zero),       32'(want == 32'd0));
        check({tag, ".const_ctrl"},   32'(alu_ctrl),   32'(want_ctrl));
        check({tag, ".const_sf"},     32'(shamt_ctrl), 32'(want_sf));
        check({tag, ".const_lf"},     32'(last_reg),   32'(want_lf));
    endtask

    logic [5:0] op_list [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a,
                                 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h22,
                                 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};
    logic [5:0] fn_list [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09,
                                 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h2a};

    initial begin
        logic [5:0]  r_op, r_fn;
        logic [31:0] r_a, r_b;
        rst = 1'b1; en = 1'b0; op = '0; funct = '0; a = '0; b = '0; shamt = '0;

        // Reset with random inputs, then hold with enable low
        for (int i = 0; i < 2; i++)
            step("reset", 1'b1, 1'($urandom), 6'($urandom), 6'($urandom),
                 $urandom, $urandom, 5'($urandom));
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b0, 6'($urandom), 6'($urandom),
                 $urandom, $urandom, 5'($urandom));
            check("hold.const_result", result, 32'd0);
        end

        // R-type sweep
        dir("add",  6'h00, 6'h20, 32'd2, 32'd1, 5'd0, 32'd3,        4'd3, 1'b0, 1'b0);
        dir("sub",  6'h00, 6'h22, 32'd2, 32'd1, 5'd0, 32'd1,        4'd4, 1'b0, 1'b0);
        dir("and",  6'h00, 6'h24, 32'd2, 32'd1, 5'd0, 32'd0,        4'd5, 1'b0, 1'b0);
        dir("or",   6'h00, 6'h25, 32'd2, 32'd1, 5'd0, 32'd3,        4'd6, 1'b0, 1'b0);
        dir("xor",  6'h00, 6'h26, 32'd2, 32'd1, 5'd0, 32'd3,        4'd7, 1'b0, 1'b0);
        dir("nor",  6'h00, 6'h27, 32'd2, 32'd1, 5'd0, 32'hFFFFFFFC, 4'd8, 1'b0, 1'b0);
        dir("slt",  6'h00, 6'h2a, 32'd2, 32'd1, 5'd0, 32'd0,        4'd9, 1'b0, 1'b0);

        // Shifts
        dir("sll",  6'h00, 6'h00, 32'd2, 32'd1,        5'd3, 32'd8,        4'd0, 1'b1, 1'b0);
        dir("sllv", 6'h00, 6'h04, 32'd2, 32'd1,        5'd3, 32'd4,        4'd0, 1'b0, 1'b0);
        dir("srav", 6'h00, 6'h07, 32'd4, 32'h80000000, 5'd0, 32'hF8000000, 4'd2, 1'b0, 1'b0);
        dir("srlv", 6'h00, 6'h06, 32'd4, 32'h80000000, 5'd0, 32'h08000000, 4'd1, 1'b0, 1'b0);
        dir("srav_hi", 6'h00, 6'h07, 32'hFFFFFFE0, 32'h80000000, 5'd7, 32'h80000000, 4'd2, 1'b0, 1'b0);
        dir("sra0", 6'h00, 6'h03, 32'd9, 32'h80000001, 5'd0, 32'h80000001, 4'd2, 1'b1, 1'b0);

        // I-type and branches
        dir("beq",  6'h04, 6'h15, 32'd5,        32'd5,     5'd0, 32'd0,        4'd4, 1'b0, 1'b0);
        dir("bne",  6'h05, 6'h00, 32'd2,        32'd1,     5'd0, 32'd1,        4'd4, 1'b0, 1'b0);
        dir("slti", 6'h0a, 6'h00, 32'hFFFFFFFF, 32'd1,     5'd0, 32'd1,        4'd9, 1'b0, 1'b0);
        dir("lui",  6'h0f, 6'h00, 32'h12345678, 32'd1,     5'd0, 32'h00010000, 4'd10, 1'b0, 1'b0);
        dir("lw",   6'h23, 6'h00, 32'h100,      32'd4,     5'd0, 32'h104,      4'd3, 1'b0, 1'b0);
        dir("addwrap", 6'h08, 6'h00, 32'hFFFFFFFF, 32'd1,  5'd0, 32'd0,        4'd3, 1'b0, 1'b0);

        // Jumps and unknowns
        dir("jal",  6'h03, 6'h00, 32'd8, 32'd4, 5'd0, 32'd12, 4'd3, 1'b0, 1'b1);
        dir("jalr", 6'h00, 6'h09, 32'd8, 32'd4, 5'd0, 32'd12, 4'd3, 1'b0, 1'b0);
        dir("unk_op", 6'h3F, 6'h00, 32'd7, 32'd5, 5'd4, 32'd12, 4'd3, 1'b0, 1'b0);
        dir("unk_fn", 6'h00, 6'h3F, 32'd7, 32'd5, 5'd4, 32'd12, 4'd3, 1'b0, 1'b0);

        // Enable low after a nonzero result must hold it
        step("hold2", 1'b0, 1'b0, 6'h00, 6'h22, 32'd1, 32'd1, 5'd0);
        check("hold2.const_result", result, 32'd12);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r_op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 19)];
            r_fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 15)];
            r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            step("rand", 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
                 r_op, r_fn, r_a, r_b, 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered execute-stage block for the MIPS pipeline.
- Decodes instruction opcode and R-type function code into a 4-bit ALU operation plus two datapath control flags.
- Performs the 32-bit ALU operation and registers result, zero flag and control outputs on the clock edge.
- Sits between ID/EX operand selection and the EX/MEM register.

Parameters:
- NB_REG, 32, operand/result width
- NB_FCODE, 6, function code width
- NB_OPCODE, 6, opcode width
- NB_ALU_CTRL, 4, internal ALU operation code width
- NB_SHAMT, 5, shift amount width

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  1 = capture new outputs this edge; 0 = hold all outputs
- i_funct_code  in  6  R-type function field
- i_ALU_op  in  6  instruction opcode
- i_A  in  32  operand A (rs)
- i_B  in  32  operand B (rt or extended immediate)
- i_shamt  in  5  instruction shamt field
- o_result  out  32  registered ALU result
- o_zero  out  1  registered, 1 when the computed result is 0
- o_ALU_ctrl  out  4  registered operation code
- o_shamt_ctrl  out  1  registered, 1 for SLL/SRL/SRA (shift by shamt field)
- o_last_register_ctrl  out  1  registered, 1 for JAL (write link to r31)

Behaviour:
- Reset: on a rising edge with i_reset=1, all outputs go to 0, including o_zero. Reset has priority over i_enable.
- Latency: one cycle. Decode and ALU are combinational; outputs update on the edge where i_enable=1 and i_reset=0. With i_enable=0, outputs hold.
- ALU op codes:
  - 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 LUI.
  - Codes 11-15 give result 0.
- Opcode decode when i_ALU_op=0x00 (R-type), by function code:
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: shamt flag 1.
  - 0x04 SLLV→SLL, 0x06 SRLV→SRL, 0x07 SRAV→SRA: shamt flag 0.
  - 0x09 JALR→ADD.
  - 0x20/0x21→ADD, 0x22/0x23→SUB.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2a SLT.
  - Unknown funct→ADD, flags 0.
- Other opcodes:
  - 0x02 J→ADD.
  - 0x03 JAL→ADD, last_register flag 1.
  - 0x04 BEQ, 0x05 BNE→SUB.
  - 0x08 ADDI→ADD, 0x0a SLTI→SLT, 0x0c ANDI→AND, 0x0d ORI→OR, 0x0e XORI→XOR, 0x0f LUI→LUI.
  - Loads 0x20-0x25 and stores 0x28/0x29/0x2b→ADD.
  - Unknown opcode→ADD, flags 0.
- Arithmetic: ADD/SUB are 32-bit modulo, with no overflow trap or flag; signed and unsigned variants are identical.
- SLT: signed compare; result is 1 when A<B, else 0.
- Shifts: operand B is shifted. The amount is i_shamt when the shamt flag is 1, else i_A[4:0]; upper bits of A are ignored.
  - SRA replicates B[31].
  - A shift amount of 0 passes B through.
- LUI: result = {B[15:0],16'h0}. Operand A is ignored.
- NOR = ~(A|B).
- o_zero: 1 exactly when the registered result is 32'h0. Branch taken/not-taken is decided outside this block.

Test Plan:
- Reset: i_reset=1 for 2 edges with random inputs → all outputs 0. Then i_enable=0 with changing inputs → outputs stay 0.
- R-type sweep, A=2, B=1, enable=1:
  - ADD→3, SUB→1.
  - AND→0 with o_zero=1.
  - OR→3, XOR→3, NOR→0xFFFFFFFC.
  - SLT→0 with o_zero=1.
  - Each result appears one edge after inputs are applied.
- Shifts:
  - SLL, shamt=3, A=2, B=1 → 8, o_shamt_ctrl=1.
  - SLLV, A=2, B=1 → 4, o_shamt_ctrl=0.
  - SRAV, A=4, B=0x80000000 → 0xF8000000.
  - SRLV, A=4, B=0x80000000 → 0x08000000.
- I-type/branch:
  - BEQ, A=B=5 → result 0, o_zero=1, o_ALU_ctrl=4.
  - BNE, A=2, B=1 → result 1, o_zero=0.
  - SLTI, A=0xFFFFFFFF, B=1 → 1.
  - LUI, B=1 → 0x00010000.
  - LW, A=0x100, B=4 → 0x104.
- Jumps:
  - JAL → o_last_register_ctrl=1, o_ALU_ctrl=3.
  - JALR (R-type, funct 0x09) → last_register=0, ADD.
  - Unknown opcode 0x3F → ADD, both flags 0.
